// File: rtl/fetch_decode_unit.sv
// Instruction fetch and register-field decode front end feeding register_file.
// Fetches one RV64I word per handshake, holds it until acknowledged, halts on illegal opcodes.
module fetch_decode_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic [31:0]     imemData,
    input  logic            instrAck,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] branchTarget,
    output logic            instrValid,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] pcOut,
    output logic [4:0]      readRegister1,
    output logic [4:0]      readRegister2,
    output logic [4:0]      writeRegister,
    output logic            regWrite,
    output logic            illegalInstr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } state_t;

    state_t state;

    logic            op_legal;
    logic            op_writes;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        op_legal  = 1'b1;
        op_writes = 1'b0;
        unique case (imemData[6:0])
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b0111011, 7'b0011011: op_writes = 1'b1;
            7'b0100011, 7'b1100011:             op_writes = 1'b0;
            default:                            op_legal  = 1'b0;
        endcase
    end

    // Redirect targets are forced word-aligned by masking the low two bits.
    assign redirect_pc = branchTarget & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign next_pc     = branchTaken ? redirect_pc : pcOut + XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            pcOut        <= RESET_PC;
            instruction  <= NOP;
            instrValid   <= 1'b0;
            regWrite     <= 1'b0;
            illegalInstr <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imemReady) begin
                        instruction <= imemData;
                        if (op_legal) begin
                            state      <= HOLD;
                            instrValid <= 1'b1;
                            regWrite   <= op_writes && (imemData[11:7] != 5'd0);
                        end else begin
                            state        <= HALT;
                            instrValid   <= 1'b0;
                            regWrite     <= 1'b0;
                            illegalInstr <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (instrAck) begin
                        state      <= FETCH;
                        pcOut      <= next_pc;
                        instrValid <= 1'b0;
                        regWrite   <= 1'b0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Request drops combinationally with reset so nothing is issued while it is held.
    assign imemReq       = (state == FETCH) && !reset;
    assign imemAddr      = pcOut;
    assign readRegister1 = instruction[19:15];
    assign readRegister2 = instruction[24:20];
    assign writeRegister = instruction[11:7];

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Sequential front end that sits directly upstream of register_file.
- Holds the PC and fetches 32-bit RV64I instructions from instruction memory over a req/ready handshake.
- Latches each fetched word and decodes its register fields, driving readRegister1/readRegister2/writeRegister/regWrite into register_file.
- Advances the PC (sequential or redirect) only when the downstream datapath acknowledges the instruction.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.
- XLEN, 64, PC and target width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imemReq  output  1  fetch request; held high in FETCH until accepted.
- imemAddr  output  XLEN  fetch address, always equals pcOut.
- imemReady  input  1  memory returns imemData this cycle; a transfer occurs when imemReq && imemReady.
- imemData  input  32  instruction word, sampled on transfer.
- instrAck  input  1  downstream consumed the current instruction.
- branchTaken  input  1  redirect request, sampled only with instrAck.
- branchTarget  input  XLEN  redirect address; bits [1:0] are ignored and forced to 0.
- instrValid  output  1  instruction/decode outputs are valid.
- instruction  output  32  latched instruction word.
- pcOut  output  XLEN  PC of the current or pending instruction.
- readRegister1  output  5  instruction[19:15].
- readRegister2  output  5  instruction[24:20].
- writeRegister  output  5  instruction[11:7].
- regWrite  output  1  decoded register-write enable.
- illegalInstr  output  1  sticky illegal-opcode flag.

Behaviour:
- States: FETCH, HOLD, HALT.
- Reset (async, immediate):
  - state = FETCH, pcOut = RESET_PC.
  - instruction = 32'h00000013 (NOP); register fields reflect the NOP (readRegister1 = 0, readRegister2 = 0, writeRegister = 0).
  - instrValid = 0, regWrite = 0, illegalInstr = 0, imemReq = 0 while reset is asserted.
- FETCH:
  - imemReq = 1, imemAddr = pcOut.
  - On the edge where imemReady = 1: latch imemData into instruction and decode it.
  - Legal opcode: go to HOLD; instrValid rises the following cycle (fetch latency = 1 cycle after the transfer edge).
  - Zero-wait memory (imemReady already high in the request cycle) is legal.
  - imemReady with imemReq low is ignored.
- HOLD:
  - imemReq = 0; instrValid = 1; all decode outputs stable.
  - On instrAck = 1:
    - pcOut <= branchTaken ? {branchTarget[XLEN-1:2], 2'b00} : pcOut + 4.
    - Go to FETCH; instrValid = 0 from the next cycle.
  - branchTaken without instrAck has no effect.
- PC arithmetic:
  - Modulo 2^XLEN.
  - pcOut = 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Decode:
  - Legal opcodes with regWrite = 1: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, 0111011, 0011011.
  - Legal opcodes with regWrite = 0: 0100011 (store), 1100011 (branch).
  - regWrite is forced to 0 when writeRegister == 0.
  - Register fields are driven from the latched instruction regardless of opcode.
- Illegal opcode (any other opcode on transfer):
  - Go to HALT; illegalInstr = 1, instrValid = 0, regWrite = 0.
  - imemReq stays 0; pcOut holds the faulting PC.
  - HALT exits only on reset.
- instrAck in FETCH or HALT is ignored.
- Reset asserted mid-handshake (FETCH waiting, or HOLD):
  - Transaction abandoned; restart from RESET_PC.
  - A late imemReady in the first cycle after reset deassert is treated as a fresh transfer for RESET_PC.
- Register fields change only on a transfer edge; they never glitch during HOLD.

Test Plan:
- Reset with RESET_PC = 0, then imemReady = 1 after 2 wait cycles with data 32'h003100B3 (add x1,x2,x3) → imemAddr = 0 during the wait; then instrValid = 1, readRegister1 = 2, readRegister2 = 3, writeRegister = 1, regWrite = 1.
- Ack with branchTaken = 0 → next imemAddr = 4. Then fetch 32'h00113023 (sd x1,0(x2)) → regWrite = 0, readRegister1 = 2, readRegister2 = 1.
- Fetch 32'h00000013 (addi x0,x0,0) → writeRegister = 0, regWrite = 0.
- Ack with branchTaken = 1, branchTarget = 64'h103 → pcOut = 64'h100, imemAddr = 64'h100. Separately, branchTaken = 1 with instrAck = 0 → pcOut unchanged.
- Fetch 32'hFFFFFFFF → illegalInstr = 1, instrValid = 0, imemReq stays 0 for 10 cycles with imemReady toggling. Assert reset → illegalInstr = 0, pcOut = RESET_PC immediately.
- Zero-wait fetch with imemReady tied high, plus pcOut = 64'hFFFF_FFFF_FFFF_FFFC acknowledged → pcOut wraps to 0. Assert reset asynchronously between clock edges during HOLD → instrValid drops without waiting for a clock edge.
